// File: rtl/pac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pac
// Purpose  : Packet admission controller. Buffers whole packets in a data
//            FIFO with their action in a side FIFO, drops packets that find
//            no room or carry no/invalid action, and forwards admitted
//            packets with a decoded destination portmap.
// Ports    : clk, rst_n (sync, active-low)
//            in_pac_data[133:0]/_wr  : input words, [133:132] 01 head,
//                                      11 middle, 10 tail
//            in_pac_valid/_wr        : end-of-packet marker (unused)
//            in_pac_action[10:0]/_wr : {mode, pkttype, port}, with head
//            in_pac_alf              : downstream almost-full
//            out_pac_data[133:0]/_wr : forwarded word and strobe
//            out_pac_valid/_wr       : tail-word marker
//            out_pac_portmap[2:0]    : destination bitmap, per packet
//            out_pac_pkttype[2:0]    : packet type, per packet
//            pac_drop_cnt[31:0]      : saturating drop counter, present
//                                      only with PAC_DROP_CNT_EN defined
// Revision : 1.0 - initial release
// ============================================================================
module pac (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [133:0]  in_pac_data,
   input  logic          in_pac_data_wr,
   input  logic          in_pac_valid,
   input  logic          in_pac_valid_wr,
   input  logic [10:0]   in_pac_action,
   input  logic          in_pac_action_wr,
   input  logic          in_pac_alf,
   output logic [133:0]  out_pac_data,
   output logic          out_pac_data_wr,
   output logic          out_pac_valid,
   output logic          out_pac_valid_wr,
   output logic [2:0]    out_pac_portmap,
   output logic [2:0]    out_pac_pkttype
`ifdef PAC_DROP_CNT_EN
   ,
   output logic [31:0]   pac_drop_cnt
`endif
);

   localparam logic [1:0] c_HEAD     = 2'b01;
   localparam logic [1:0] c_TAIL     = 2'b10;
   localparam logic [8:0] c_ADMIT    = 9'd128;  // max occupancy admitting a head
   localparam logic [8:0] c_D_FULL   = 9'd256;
   localparam logic [4:0] c_A_FULL   = 5'd16;

   typedef enum logic [1:0] {IN_IDLE = 2'd0, IN_WR = 2'd1, IN_DROP = 2'd2} in_state_t;
   typedef enum logic [1:0] {O_IDLE = 2'd0, O_SEND = 2'd1, O_DISC = 2'd2} out_state_t;

   in_state_t     in_state_q, in_state_d;
   out_state_t    out_state_q, out_state_d;

   logic [133:0]  dmem_q [256];
   logic [7:0]    dwptr_q, drptr_q;
   logic [8:0]    dcnt_q;
   logic [10:0]   amem_q [16];
   logic [3:0]    awptr_q, arptr_q;
   logic [4:0]    acnt_q;

   logic          s1_vld_q;
   logic [133:0]  s1_data_q;
   logic [2:0]    pm_q, pt_q;
   logic [2:0]    pm_out_q, pt_out_q;
   logic [133:0]  out_data_q;
   logic          out_wr_q, out_valid_q;

   logic          w_head, w_tail, w_d_wr, w_a_wr, w_d_rd, w_a_rd, w_s1_ld;
   logic          w_drop_in, w_drop_out, w_dtail;
   logic [10:0]   w_act;
   logic [2:0]    w_pm;

   logic          w_unused_inputs;
   assign w_unused_inputs = in_pac_valid ^ in_pac_valid_wr;

   assign w_head  = in_pac_data_wr && (in_pac_data[133:132] == c_HEAD);
   assign w_tail  = in_pac_data_wr && (in_pac_data[133:132] == c_TAIL);
   assign w_act   = amem_q[arptr_q];
   assign w_dtail = (dmem_q[drptr_q][133:132] == c_TAIL);

   // Action decode; port numbers above 2 are invalid in every mode.
   always_comb begin
      w_pm = 3'b000;
      if (w_act[5:0] <= 6'd2) begin
         if (w_act[10:9] == 2'b00)
            w_pm = 3'b001 << w_act[1:0];
         else if (w_act[10:9] == 2'b10)
            w_pm = 3'b100 | (3'b001 << w_act[0]);
      end
   end

   // Input FSM: admission decision is made once, on the head word.
   always_comb begin
      in_state_d = in_state_q;
      w_d_wr     = 1'b0;
      w_a_wr     = 1'b0;
      w_drop_in  = 1'b0;
      case (in_state_q)
         IN_IDLE: begin
            if (w_head) begin
               if (in_pac_action_wr && (dcnt_q <= c_ADMIT) && (acnt_q != c_A_FULL)) begin
                  w_d_wr     = 1'b1;
                  w_a_wr     = 1'b1;
                  in_state_d = IN_WR;
               end else begin
                  w_drop_in  = 1'b1;
                  in_state_d = IN_DROP;
               end
            end
         end
         IN_WR: begin
            w_d_wr = in_pac_data_wr && (dcnt_q != c_D_FULL);
            if (w_tail)
               in_state_d = IN_IDLE;
         end
         IN_DROP: begin
            if (w_tail)
               in_state_d = IN_IDLE;
         end
         default: in_state_d = IN_IDLE;
      endcase
   end

   // Output FSM: alf only gates the start of a packet.
   always_comb begin
      out_state_d = out_state_q;
      w_a_rd      = 1'b0;
      w_d_rd      = 1'b0;
      w_s1_ld     = 1'b0;
      w_drop_out  = 1'b0;
      case (out_state_q)
         O_IDLE: begin
            if ((acnt_q != 5'd0) && !in_pac_alf) begin
               w_a_rd = 1'b1;
               if (w_pm != 3'b000) begin
                  out_state_d = O_SEND;
               end else begin
                  w_drop_out  = 1'b1;
                  out_state_d = O_DISC;
               end
            end
         end
         O_SEND, O_DISC: begin
            if (dcnt_q != 9'd0) begin
               w_d_rd  = 1'b1;
               w_s1_ld = (out_state_q == O_SEND);
               if (w_dtail)
                  out_state_d = O_IDLE;
            end
         end
         default: out_state_d = O_IDLE;
      endcase
   end

   // Storage arrays are not reset; pointer/count reset empties them.
   always_ff @(posedge clk) begin
      if (w_d_wr)
         dmem_q[dwptr_q] <= in_pac_data;
      if (w_a_wr)
         amem_q[awptr_q] <= in_pac_action;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_state_q  <= IN_IDLE;
         out_state_q <= O_IDLE;
         dwptr_q     <= '0;
         drptr_q     <= '0;
         dcnt_q      <= '0;
         awptr_q     <= '0;
         arptr_q     <= '0;
         acnt_q      <= '0;
         s1_vld_q    <= 1'b0;
         s1_data_q   <= '0;
         pm_q        <= '0;
         pt_q        <= '0;
         pm_out_q    <= '0;
         pt_out_q    <= '0;
         out_data_q  <= '0;
         out_wr_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         in_state_q  <= in_state_d;
         out_state_q <= out_state_d;
         if (w_d_wr) dwptr_q <= dwptr_q + 8'd1;
         if (w_d_rd) drptr_q <= drptr_q + 8'd1;
         dcnt_q      <= dcnt_q + {8'd0, w_d_wr} - {8'd0, w_d_rd};
         if (w_a_wr) awptr_q <= awptr_q + 4'd1;
         if (w_a_rd) begin
            arptr_q <= arptr_q + 4'd1;
            pm_q    <= w_pm;
            pt_q    <= w_act[8:6];
         end
         acnt_q      <= acnt_q + {4'd0, w_a_wr} - {4'd0, w_a_rd};
         s1_vld_q    <= w_s1_ld;
         if (w_s1_ld)
            s1_data_q <= dmem_q[drptr_q];
         // Portmap/pkttype switch when the head reaches the output, so the
         // previous packet keeps its values through its tail word.
         if (s1_vld_q && (s1_data_q[133:132] == c_HEAD)) begin
            pm_out_q <= pm_q;
            pt_out_q <= pt_q;
         end
         out_wr_q    <= s1_vld_q;
         out_data_q  <= s1_vld_q ? s1_data_q : '0;
         out_valid_q <= s1_vld_q && (s1_data_q[133:132] == c_TAIL);
      end
   end

   assign out_pac_data     = out_data_q;
   assign out_pac_data_wr  = out_wr_q;
   assign out_pac_valid    = out_valid_q;
   assign out_pac_valid_wr = out_valid_q;
   assign out_pac_portmap  = pm_out_q;
   assign out_pac_pkttype  = pt_out_q;

`ifdef PAC_DROP_CNT_EN
   logic [31:0] drop_cnt_q;
   logic [32:0] w_drop_sum;

   // Input and output drops can coincide, so up to 2 per cycle.
   assign w_drop_sum = {1'b0, drop_cnt_q} + {32'd0, w_drop_in} + {32'd0, w_drop_out};

   always_ff @(posedge clk) begin
      if (!rst_n)
         drop_cnt_q <= '0;
      else
         drop_cnt_q <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
   end

   assign pac_drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pac
// Purpose  : Directed self-checking bench for pac.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pac;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [133:0]  in_pac_data;
   logic          in_pac_data_wr, in_pac_valid, in_pac_valid_wr;
   logic [10:0]   in_pac_action;
   logic          in_pac_action_wr, in_pac_alf;
   logic [133:0]  out_pac_data;
   logic          out_pac_data_wr, out_pac_valid, out_pac_valid_wr;
   logic [2:0]    out_pac_portmap, out_pac_pkttype;
`ifdef PAC_DROP_CNT_EN
   logic [31:0]   pac_drop_cnt;
`endif

   pac u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_pac_data      (in_pac_data),
      .in_pac_data_wr   (in_pac_data_wr),
      .in_pac_valid     (in_pac_valid),
      .in_pac_valid_wr  (in_pac_valid_wr),
      .in_pac_action    (in_pac_action),
      .in_pac_action_wr (in_pac_action_wr),
      .in_pac_alf       (in_pac_alf),
      .out_pac_data     (out_pac_data),
      .out_pac_data_wr  (out_pac_data_wr),
      .out_pac_valid    (out_pac_valid),
      .out_pac_valid_wr (out_pac_valid_wr),
      .out_pac_portmap  (out_pac_portmap),
      .out_pac_pkttype  (out_pac_pkttype)
`ifdef PAC_DROP_CNT_EN
      ,
      .pac_drop_cnt     (pac_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [10:0] c_A033 = 11'b00_001_000010;          // pm 100 pt 001
   localparam logic [10:0] c_A034 = {2'b10, 3'b011, 6'd1};      // pm 110 pt 011
   localparam logic [10:0] c_AP5  = {2'b00, 3'b010, 6'd5};      // invalid
   localparam logic [10:0] c_AP0  = {2'b00, 3'b000, 6'd0};      // pm 001 pt 000
   localparam logic [10:0] c_AP1  = {2'b00, 3'b101, 6'd1};      // pm 010 pt 101

   typedef struct {
      int           cyc;
      logic [133:0] data;
      logic         v;
      logic         vwr;
      logic [2:0]   pm;
      logic [2:0]   pt;
   } mon_t;

   mon_t mon[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   zero_viol = 0;
   int   h, h2, r;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (out_pac_data_wr)
         mon.push_back('{cyc: cyc, data: out_pac_data, v: out_pac_valid,
                         vwr: out_pac_valid_wr, pm: out_pac_portmap, pt: out_pac_pkttype});
      else if ((out_pac_data != '0) || out_pac_valid || out_pac_valid_wr)
         zero_viol++;
   end

   task automatic check(input string tag, input logic [133:0] act, input logic [133:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_drop(input int exp);
`ifdef PAC_DROP_CNT_EN
      check("drop_cnt", 134'(pac_drop_cnt), 134'(exp));
`endif
   endtask

   function automatic logic [133:0] mkword(input int id, input int idx, input int n);
      logic [1:0] t;
      t = (idx == 0) ? 2'b01 : ((idx == n - 1) ? 2'b10 : 2'b11);
      return {t, 116'(id), 16'(idx)};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [133:0] d, input logic awr, input logic [10:0] act);
      in_pac_data      = d;
      in_pac_data_wr   = 1'b1;
      in_pac_action_wr = awr;
      in_pac_action    = awr ? act : 11'd0;
      in_pac_valid     = (d[133:132] == 2'b10);
      in_pac_valid_wr  = (d[133:132] == 2'b10);
      @(posedge clk);
      #1;
      in_pac_data      = '0;
      in_pac_data_wr   = 1'b0;
      in_pac_action_wr = 1'b0;
      in_pac_action    = '0;
      in_pac_valid     = 1'b0;
      in_pac_valid_wr  = 1'b0;
   endtask

   // hcyc: cycle count of the edge that captured the head word.
   task automatic send_pkt(input int id, input int n, input logic [10:0] act,
                           input logic awr, input int alf_at, output int hcyc);
      hcyc = 0;
      for (int i = 0; i < n; i++) begin
         drive(mkword(id, i, n), (i == 0) && awr, act);
         if (i == 0) hcyc = cyc;
         if (i == alf_at) in_pac_alf = 1'b1;
      end
   endtask

   task automatic check_pkt(input string tag, input int base, input int id, input int n,
                            input logic [2:0] pm, input logic [2:0] pt, input int start);
      int bad;
      bad = 0;
      if (mon.size() < base + n) begin
         bad = n;
      end else begin
         for (int i = 0; i < n; i++) begin
            if ((mon[base+i].data !== mkword(id, i, n)) || (mon[base+i].cyc != start + i) ||
                (mon[base+i].pm !== pm) || (mon[base+i].pt !== pt) ||
                (mon[base+i].v !== (i == n - 1)) || (mon[base+i].vwr !== (i == n - 1)))
               bad++;
         end
      end
      check({tag, "_bad_words"}, 134'(bad), 134'd0);
      check({tag, "_start_cyc"}, (mon.size() > base) ? 134'(mon[base].cyc) : 134'd0, 134'(start));
   endtask

   initial begin
      rst_n            = 1'b0;
      in_pac_data      = '0;
      in_pac_data_wr   = 1'b0;
      in_pac_valid     = 1'b0;
      in_pac_valid_wr  = 1'b0;
      in_pac_action    = '0;
      in_pac_action_wr = 1'b0;
      in_pac_alf       = 1'b0;
      idle(3);
      check("rst_data_wr", 134'(out_pac_data_wr), 134'd0);
      check("rst_data", out_pac_data, 134'd0);
      check("rst_valid", 134'({out_pac_valid, out_pac_valid_wr}), 134'd0);
      check("rst_pm_pt", 134'({out_pac_portmap, out_pac_pkttype}), 134'd0);
      check_drop(0);
      rst_n = 1'b1;
      idle(2);

      // Basic 4-word packet, latency 3, portmap 100.
      mon.delete();
      send_pkt(1, 4, c_A033, 1'b1, -1, h);
      idle(8);
      check("p033_count", 134'(mon.size()), 134'd4);
      check_pkt("p033", 0, 1, 4, 3'b100, 3'b001, h + 3);

      // Mode 10, port 1.
      mon.delete();
      send_pkt(2, 3, c_A034, 1'b1, -1, h);
      idle(8);
      check("p034_count", 134'(mon.size()), 134'd3);
      check_pkt("p034", 0, 2, 3, 3'b110, 3'b011, h + 3);

      // Invalid port: discarded, FIFO drains so the next packet is clean.
      mon.delete();
      send_pkt(3, 3, c_AP5, 1'b1, -1, h);
      idle(8);
      check("p035_none", 134'(mon.size()), 134'd0);
      check_drop(1);
      send_pkt(4, 2, c_AP0, 1'b1, -1, h);
      idle(8);
      check_pkt("p035_next", 0, 4, 2, 3'b001, 3'b000, h + 3);

      // Head without action strobe is dropped.
      mon.delete();
      send_pkt(5, 3, c_AP0, 1'b0, -1, h);
      idle(6);
      check("noact_none", 134'(mon.size()), 134'd0);
      check_drop(2);

      // Stray middle/tail words in idle are ignored.
      drive(mkword(6, 1, 3), 1'b0, 11'd0);
      drive(mkword(6, 2, 3), 1'b0, 11'd0);
      send_pkt(7, 3, c_AP1, 1'b1, -1, h);
      idle(8);
      check("stray_count", 134'(mon.size()), 134'd3);
      check_pkt("stray", 0, 7, 3, 3'b010, 3'b101, h + 3);

      // alf held: 3 x 100 words, the third finds only 56 free.
      mon.delete();
      in_pac_alf = 1'b1;
      send_pkt(10, 100, c_AP0, 1'b1, -1, h);
      send_pkt(11, 100, c_AP0, 1'b1, -1, h);
      send_pkt(12, 100, c_AP0, 1'b1, -1, h);
      idle(5);
      check("alf_hold_none", 134'(mon.size()), 134'd0);
      check_drop(3);
      in_pac_alf = 1'b0;
      r = cyc;
      idle(230);
      check("alf_count", 134'(mon.size()), 134'd200);
      check_pkt("alf_p1", 0, 10, 100, 3'b001, 3'b000, r + 3);
      check_pkt("alf_p2", 100, 11, 100, 3'b001, 3'b000, r + 104);

      // alf raised during an O_SEND packet.
      mon.delete();
      send_pkt(20, 8, c_A033, 1'b1, 5, h);
      send_pkt(21, 4, c_AP1, 1'b1, -1, h2);
      idle(10);
      check("alfmid_a_only", 134'(mon.size()), 134'd8);
      check_pkt("alfmid_a", 0, 20, 8, 3'b100, 3'b001, h + 3);
      in_pac_alf = 1'b0;
      r = cyc;
      idle(10);
      check("alfmid_count", 134'(mon.size()), 134'd12);
      check_pkt("alfmid_b", 8, 21, 4, 3'b010, 3'b101, r + 3);

      // Reset at word 3 of a 6-word packet.
      mon.delete();
      for (int i = 0; i < 3; i++)
         drive(mkword(30, i, 6), i == 0, c_AP0);
      rst_n = 1'b0;
      drive(mkword(30, 3, 6), 1'b0, 11'd0);
      check("midrst_data_wr", 134'(out_pac_data_wr), 134'd0);
      check("midrst_data", out_pac_data, 134'd0);
      check("midrst_valid", 134'({out_pac_valid, out_pac_valid_wr}), 134'd0);
      check("midrst_pm_pt", 134'({out_pac_portmap, out_pac_pkttype}), 134'd0);
      check_drop(0);
      rst_n = 1'b1;
      drive(mkword(30, 4, 6), 1'b0, 11'd0);
      drive(mkword(30, 5, 6), 1'b0, 11'd0);
      idle(6);
      check("midrst_none", 134'(mon.size()), 134'd0);
      send_pkt(31, 4, c_A033, 1'b1, -1, h);
      idle(8);
      check("midrst_next_count", 134'(mon.size()), 134'd4);
      check_pkt("midrst_next", 0, 31, 4, 3'b100, 3'b001, h + 3);
      check_drop(0);

      check("data_zero_when_idle", 134'(zero_viol), 134'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
